// File: rtl/ptw_pkg.sv
// Shared types and constants for the Sv32-style page table walker.
// Provides the walker state enum, PTE field positions, and the packed PTE layout.
package ptw_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned PPN_W  = 20;   // physical page number returned to the TLB
    localparam int unsigned VPN_W  = 10;   // one VPN level
    localparam int unsigned PTE_W  = 32;

    localparam logic [ADDR_W-1:0] ROOT_BASE = 32'h0000_1000;

    // PTE bit positions
    localparam int unsigned PTE_V_BIT   = 0;
    localparam int unsigned PTE_R_BIT   = 1;
    localparam int unsigned PTE_W_BIT   = 2;
    localparam int unsigned PTE_X_BIT   = 3;
    localparam int unsigned PTE_PPN_LSB = 10;
    localparam int unsigned PTE_PPN_MSB = 31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        L1_REQ  = 3'd1,
        L1_WAIT = 3'd2,
        L0_REQ  = 3'd3,
        L0_WAIT = 3'd4,
        RESP    = 3'd5
    } state_t;

    // ppn[21:20] (pte[31:30]) lies outside the 32-bit physical space and is ignored
    typedef struct packed {
        logic [21:0] ppn;
        logic [1:0]  rsw;
        logic        d;
        logic        a;
        logic        g;
        logic        u;
        logic        x;
        logic        w;
        logic        r;
        logic        v;
    } pte_t;

endpackage

// File: rtl/pte_check.sv
// Combinational PTE decode shared by both walk levels.
// Ports: pte_i (raw PTE), is_l1_i (1 = level-1 entry), valid_o, leaf_o,
//        misaligned_o (superpage low PPN bits nonzero), fault_o.
// Build option: PTW_SUPERPAGE_EN allows aligned leaf L1 entries (4 MB superpages);
//        without it every leaf L1 entry faults.
module pte_check
    import ptw_pkg::*;
(
    input  pte_t pte_i,
    input  logic is_l1_i,
    output logic valid_o,
    output logic leaf_o,
    output logic misaligned_o,
    output logic fault_o
);

    logic wr_no_rd;
    logic l1_leaf_bad;
    logic leaf_bad;
    logic unused_pte;

    assign valid_o      = pte_i.v;
    assign leaf_o       = pte_i.r | pte_i.x;
    assign misaligned_o = (pte_i.ppn[VPN_W-1:0] != '0);
    assign wr_no_rd     = pte_i.w & ~pte_i.r;

`ifdef PTW_SUPERPAGE_EN
    assign l1_leaf_bad = misaligned_o;
`else
    assign l1_leaf_bad = 1'b1;
`endif

    // L1: only a bad superpage faults here; L0: a pointer has nowhere left to go
    assign leaf_bad = is_l1_i ? (leaf_o & l1_leaf_bad) : ~leaf_o;
    assign fault_o  = ~pte_i.v | wr_no_rd | leaf_bad;

    assign unused_pte = ^{pte_i.ppn[21:VPN_W], pte_i.rsw, pte_i.d, pte_i.a, pte_i.g, pte_i.u};

endmodule

// File: rtl/page_table_walker.sv
// Two-level Sv32-style page table walker between the TLB miss path and word memory.
// Ports: clk, rst (sync, active high);
//        walk_req_valid_i/walk_req_ready_o/walk_vaddr_i   - walk request from TLB
//        walk_resp_valid_o/walk_resp_ready_i/walk_ppn_o/walk_fault_o - walk result
//        mem_req_valid_o/mem_req_ready_i/mem_addr_o       - PTE read request
//        mem_resp_valid_i/mem_resp_ready_o/mem_data_i     - PTE read data
// Build option: PTW_SUPERPAGE_EN enables 4 MB superpage leaves at level 1.
// All outputs are registered; one memory read outstanding at most.
module page_table_walker
    import ptw_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              walk_req_valid_i,
    output logic              walk_req_ready_o,
    input  logic [ADDR_W-1:0] walk_vaddr_i,
    output logic              walk_resp_valid_o,
    input  logic              walk_resp_ready_i,
    output logic [PPN_W-1:0]  walk_ppn_o,
    output logic              walk_fault_o,
    output logic              mem_req_valid_o,
    input  logic              mem_req_ready_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_resp_valid_i,
    output logic              mem_resp_ready_o,
    input  logic [PTE_W-1:0]  mem_data_i
);

    state_t              state_q, state_d;
    logic [VPN_W-1:0]    vpn0_q, vpn0_d;
    logic                req_ready_q, req_ready_d;
    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                mem_resp_ready_q, mem_resp_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [PPN_W-1:0]    ppn_q, ppn_d;
    logic                fault_q, fault_d;

    pte_t pte;
    logic pte_valid, pte_leaf, pte_misaligned, pte_fault;
    logic unused_bits;

    assign pte = pte_t'(mem_data_i);

    // Decode the PTE arriving this cycle; level chosen by which wait state we are in
    pte_check u_pte_check (
        .pte_i        (pte),
        .is_l1_i      (state_q == L1_WAIT),
        .valid_o      (pte_valid),
        .leaf_o       (pte_leaf),
        .misaligned_o (pte_misaligned),
        .fault_o      (pte_fault)
    );

    assign unused_bits = ^{walk_vaddr_i[11:0], pte_valid, pte_misaligned};

    // Next-state and next-output logic
    always_comb begin
        state_d          = state_q;
        vpn0_d           = vpn0_q;
        req_ready_d      = 1'b0;
        mem_req_valid_d  = 1'b0;
        mem_addr_d       = mem_addr_q;
        mem_resp_ready_d = 1'b0;
        resp_valid_d     = 1'b0;
        ppn_d            = ppn_q;
        fault_d          = fault_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (walk_req_valid_i) begin
                    state_d         = L1_REQ;
                    req_ready_d     = 1'b0;
                    vpn0_d          = walk_vaddr_i[21:12];
                    mem_req_valid_d = 1'b1;
                    mem_addr_d      = ROOT_BASE + ADDR_W'({walk_vaddr_i[31:22], 2'b00});
                end
            end

            L1_REQ, L0_REQ: begin
                mem_req_valid_d = 1'b1;
                if (mem_req_ready_i) begin
                    mem_req_valid_d  = 1'b0;
                    mem_resp_ready_d = 1'b1;
                    state_d          = (state_q == L1_REQ) ? L1_WAIT : L0_WAIT;
                end
            end

            L1_WAIT, L0_WAIT: begin
                mem_resp_ready_d = 1'b1;
                if (mem_resp_valid_i) begin
                    mem_resp_ready_d = 1'b0;
                    if (pte_fault) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                        ppn_d        = '0;
                    end else if ((state_q == L1_WAIT) && !pte_leaf) begin
                        state_d         = L0_REQ;
                        mem_req_valid_d = 1'b1;
                        mem_addr_d      = {pte.ppn[PPN_W-1:0], vpn0_q, 2'b00};
                    end else begin
                        // Valid leaf: superpage at L1 keeps VPN[0] as the low PPN bits
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b0;
                        ppn_d        = (state_q == L1_WAIT) ?
                                       {pte.ppn[PPN_W-1:VPN_W], vpn0_q} : pte.ppn[PPN_W-1:0];
                    end
                end
            end

            RESP: begin
                resp_valid_d = 1'b1;
                if (walk_resp_ready_i) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                    ppn_d        = '0;
                    fault_d      = 1'b0;
                end
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            vpn0_q           <= '0;
            req_ready_q      <= 1'b1;
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= '0;
            mem_resp_ready_q <= 1'b0;
            resp_valid_q     <= 1'b0;
            ppn_q            <= '0;
            fault_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            vpn0_q           <= vpn0_d;
            req_ready_q      <= req_ready_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_resp_ready_q <= mem_resp_ready_d;
            resp_valid_q     <= resp_valid_d;
            ppn_q            <= ppn_d;
            fault_q          <= fault_d;
        end
    end

    assign walk_req_ready_o  = req_ready_q;
    assign mem_req_valid_o   = mem_req_valid_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_resp_ready_o  = mem_resp_ready_q;
    assign walk_resp_valid_o = resp_valid_q;
    assign walk_ppn_o        = ppn_q;
    assign walk_fault_o      = fault_q;

endmodule

// File: tb/tb_page_table_walker.sv
// Randomized self-checking bench for page_table_walker with a memory responder
// and a spec-level walk model.
module tb_page_table_walker;

    localparam logic [31:0] ROOT = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        walk_req_valid_i = 1'b0;
    logic        walk_req_ready_o;
    logic [31:0] walk_vaddr_i = '0;
    logic        walk_resp_valid_o;
    logic        walk_resp_ready_i = 1'b0;
    logic [19:0] walk_ppn_o;
    logic        walk_fault_o;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i = 1'b0;
    logic [31:0] mem_addr_o;
    logic        mem_resp_valid_i = 1'b0;
    logic        mem_resp_ready_o;
    logic [31:0] mem_data_i = '0;

    page_table_walker dut (
        .clk               (clk),
        .rst               (rst),
        .walk_req_valid_i  (walk_req_valid_i),
        .walk_req_ready_o  (walk_req_ready_o),
        .walk_vaddr_i      (walk_vaddr_i),
        .walk_resp_valid_o (walk_resp_valid_o),
        .walk_resp_ready_i (walk_resp_ready_i),
        .walk_ppn_o        (walk_ppn_o),
        .walk_fault_o      (walk_fault_o),
        .mem_req_valid_o   (mem_req_valid_o),
        .mem_req_ready_i   (mem_req_ready_i),
        .mem_addr_o        (mem_addr_o),
        .mem_resp_valid_i  (mem_resp_valid_i),
        .mem_resp_ready_o  (mem_resp_ready_o),
        .mem_data_i        (mem_data_i)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory image and model expectations
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_addr [$];
    logic [19:0] exp_ppn;
    logic        exp_fault;

    // Responder state
    bit          pending = 0;
    bit          orphan  = 0;
    logic [31:0] pend_addr;
    int          delay = 0;
    int          force_delay = -1;
    int          stall_left = 0;
    int          walk_reads = 0;
    logic [31:0] addr_log [$];
    bit          prev_v = 0;
    bit          prev_r = 0;
    logic [31:0] prev_a = '0;

    logic [19:0] got_ppn;
    logic        got_fault;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic bit pte_bad(input logic [31:0] p);
        return (p[0] == 1'b0) || (p[2] && !p[1]);
    endfunction

    // Reference walk computed directly from the translation rules
    function automatic void model_walk(input logic [31:0] va);
        logic [31:0] a1, a0, p1, p0;
        exp_addr.delete();
        exp_ppn   = '0;
        exp_fault = 1'b1;
        a1 = ROOT + {20'h0, va[31:22], 2'b00};
        exp_addr.push_back(a1);
        p1 = mem_rd(a1);
        if (pte_bad(p1)) return;
        if (p1[1] || p1[3]) begin
`ifdef PTW_SUPERPAGE_EN
            if (p1[19:10] == 10'h0) begin
                exp_fault = 1'b0;
                exp_ppn   = {p1[29:20], va[21:12]};
            end
`endif
            return;
        end
        a0 = {p1[29:10], va[21:12], 2'b00};
        exp_addr.push_back(a0);
        p0 = mem_rd(a0);
        if (pte_bad(p0) || !(p0[1] || p0[3])) return;
        exp_fault = 1'b0;
        exp_ppn   = p0[29:10];
    endfunction

    // Per-cycle compare plus memory responder (checks first, then drive)
    always @(negedge clk) begin
        if (rst) begin
            if (pending) orphan = 1;
            mem_req_ready_i  = 1'b0;
            mem_resp_valid_i = 1'b0;
            prev_v = 0;
        end else begin
            if (walk_resp_valid_o) begin
                chk("resp_ppn", 32'(walk_ppn_o), 32'(exp_ppn));
                chk("resp_fault", 32'(walk_fault_o), 32'(exp_fault));
            end
            if (mem_req_valid_o) begin
                chk("single_outstanding", 32'(pending), 0);
                if (walk_reads < exp_addr.size())
                    chk("mem_addr", mem_addr_o, exp_addr[walk_reads]);
                else
                    chk("extra_mem_req", 1, 0);
            end
            if (prev_v && !prev_r) begin
                chk("req_hold_valid", 32'(mem_req_valid_o), 1);
                chk("req_hold_addr", mem_addr_o, prev_a);
            end
            chk("mem_resp_ready", 32'(mem_resp_ready_o), 32'(pending && !orphan));

            mem_resp_valid_i = 1'b0;
            mem_data_i       = $urandom;
            if (pending) begin
                if (delay == 0) begin
                    mem_resp_valid_i = 1'b1;
                    mem_data_i       = mem_rd(pend_addr);
                    pending = 0;
                    orphan  = 0;
                end else begin
                    delay--;
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_resp_valid_i = 1'b1;   // stray pulse, must be ignored
            end

            if (mem_req_valid_o && stall_left > 0) begin
                mem_req_ready_i = 1'b0;
                stall_left--;
            end else begin
                mem_req_ready_i = ($urandom_range(0, 3) != 0);
            end
            if (mem_req_valid_o && mem_req_ready_i) begin
                pending   = 1;
                pend_addr = mem_addr_o;
                delay     = (force_delay >= 0) ? force_delay : $urandom_range(0, 3);
                walk_reads++;
                addr_log.push_back(mem_addr_o);
            end
            prev_v = mem_req_valid_o;
            prev_r = mem_req_ready_i;
            prev_a = mem_addr_o;
        end
    end

    task automatic run_walk(input logic [31:0] va, input int rstall);
        int n;
        model_walk(va);
        walk_reads = 0;
        addr_log.delete();
        n = 0;
        while (!walk_req_ready_o && n < 20) begin @(negedge clk); n++; end
        if (!walk_req_ready_o) begin chk("req_ready_timeout", 0, 1); return; end
        walk_req_valid_i = 1'b1;
        walk_vaddr_i     = va;
        @(negedge clk);
        walk_req_valid_i = 1'b0;
        walk_vaddr_i     = $urandom;
        chk("accept_clears_ready", 32'(walk_req_ready_o), 0);
        n = 0;
        while (!walk_resp_valid_o && n < 200) begin @(negedge clk); n++; end
        if (!walk_resp_valid_o) begin chk("resp_timeout", 0, 1); return; end
        got_ppn   = walk_ppn_o;
        got_fault = walk_fault_o;
        chk("busy_during_resp", 32'(walk_req_ready_o), 0);
        repeat (rstall) @(negedge clk);
        walk_resp_ready_i = 1'b1;
        @(negedge clk);
        walk_resp_ready_i = 1'b0;
        chk("resp_valid_drop", 32'(walk_resp_valid_o), 0);
        chk("ready_after_resp", 32'(walk_req_ready_o), 1);
        chk("n_reads", 32'(walk_reads), 32'(exp_addr.size()));
    endtask

    task automatic set_t1_mem();
        mem.delete();
        mem[32'h1004] = 32'h0000_0801;
        mem[32'h200C] = 32'h0001_400F;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_req_ready"}, 32'(walk_req_ready_o), 1);
        chk({tag, "_resp_valid"}, 32'(walk_resp_valid_o), 0);
        chk({tag, "_mem_req_valid"}, 32'(mem_req_valid_o), 0);
        chk({tag, "_mem_resp_ready"}, 32'(mem_resp_ready_o), 0);
        chk({tag, "_fault"}, 32'(walk_fault_o), 0);
        chk({tag, "_ppn"}, 32'(walk_ppn_o), 0);
        chk({tag, "_mem_addr"}, mem_addr_o, 0);
    endtask

    initial begin
        logic [31:0] va, l1a, l0a, p, q;
        int k, n;

        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);

        // Two-level walk to a 4 KB page
        set_t1_mem();
        run_walk(32'h0040_3000, 0);
        chk("t1_ppn", 32'(got_ppn), 32'h0000_0050);
        chk("t1_fault", 32'(got_fault), 0);
        chk("t1_reads", 32'(addr_log.size()), 2);
        if (addr_log.size() == 2) begin
            chk("t1_addr0", addr_log[0], 32'h0000_1004);
            chk("t1_addr1", addr_log[1], 32'h0000_200C);
        end

        // Leaf at level 1
        mem.delete();
        mem[32'h1004] = 32'h2000_000B;
        run_walk(32'h0040_3000, 1);
        chk("t2_reads", 32'(addr_log.size()), 1);
`ifdef PTW_SUPERPAGE_EN
        chk("t2_ppn", 32'(got_ppn), 32'h0008_0003);
        chk("t2_fault", 32'(got_fault), 0);
`else
        chk("t2_ppn", 32'(got_ppn), 0);
        chk("t2_fault", 32'(got_fault), 1);
`endif

        // Invalid and write-without-read L1 entries
        mem.delete();
        mem[32'h1004] = 32'h0000_0000;
        run_walk(32'h0040_3000, 0);
        chk("t3a_fault", 32'(got_fault), 1);
        chk("t3a_ppn", 32'(got_ppn), 0);
        chk("t3a_reads", 32'(addr_log.size()), 1);
        mem[32'h1004] = 32'h0000_0805;
        run_walk(32'h0040_3000, 0);
        chk("t3b_fault", 32'(got_fault), 1);
        chk("t3b_reads", 32'(addr_log.size()), 1);

        // Back-pressure on both the memory request and the walk response
        set_t1_mem();
        stall_left = 3;
        run_walk(32'h0040_3000, 2);
        chk("t4_ppn", 32'(got_ppn), 32'h0000_0050);
        chk("t4_fault", 32'(got_fault), 0);

        // Random walks
        for (int i = 0; i < 200; i++) begin
            va  = $urandom;
            l1a = ROOT + {20'h0, va[31:22], 2'b00};
            p   = $urandom;
            k   = $urandom_range(0, 7);
            case (k)
                0, 1, 2, 3: p[3:0] = 4'b0001;
                4: begin p[3:0] = 4'b1011; p[19:10] = '0; end
                5: p[3:0] = 4'b0011;
                6: p[3:0] = 4'b0101;
                default: ;
            endcase
            mem[l1a] = p;
            l0a = {p[29:10], va[21:12], 2'b00};
            q   = $urandom;
            if ($urandom_range(0, 2) != 0) q[1:0] = 2'b11;
            mem[l0a] = q;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_walk(va, $urandom_range(0, 3));
        end

        // Reset while waiting on the level-0 read
        set_t1_mem();
        force_delay = 6;
        model_walk(32'h0040_3000);
        walk_reads = 0;
        addr_log.delete();
        walk_req_valid_i = 1'b1;
        walk_vaddr_i     = 32'h0040_3000;
        @(negedge clk);
        walk_req_valid_i = 1'b0;
        n = 0;
        while (walk_reads < 2 && n < 100) begin @(negedge clk); n++; end
        chk("rst_test_l0_issued", 32'(walk_reads), 2);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_idle("midrst");
        @(negedge clk);
        rst = 1'b0;
        force_delay = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_ready", 32'(walk_req_ready_o), 1);
            chk("post_rst_resp_valid", 32'(walk_resp_valid_o), 0);
            chk("post_rst_mem_req", 32'(mem_req_valid_o), 0);
        end
        run_walk(32'h0040_3000, 1);
        chk("t5_ppn", 32'(got_ppn), 32'h0000_0050);
        chk("t5_fault", 32'(got_fault), 0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/page_table_walker.md
# page_table_walker

Two-level (Sv32-style) hardware page table walker between the TLB miss path and the word-addressed memory block. It accepts a virtual address from the TLB, reads the level-1 and, when needed, the level-0 PTE from memory over the valid/ready memory request/response interface, and returns a 20-bit physical page number or a fault. It acts as the initiator toward the memory block, one outstanding memory read at a time.

## Interface
- ROOT_BASE, 32'h0000_1000, byte address of the root (level-1) page table; 4 KB aligned.
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- walk_req_valid_i  input  1  TLB walk request valid.
- walk_req_ready_o  output  1  walker idle, request acceptable.
- walk_vaddr_i  input  32  virtual address; only [31:12] used.
- walk_resp_valid_o  output  1  walk result valid.
- walk_resp_ready_i  input  1  TLB accepts result.
- walk_ppn_o  output  20  translated PPN; 0 on fault.
- walk_fault_o  output  1  page fault.
- mem_req_valid_o  output  1  memory read request valid.
- mem_req_ready_i  input  1  memory accepts request.
- mem_addr_o  output  32  PTE byte address, word aligned.
- mem_resp_valid_i  input  1  memory read data valid (may be a 1-cycle pulse).
- mem_resp_ready_o  output  1  walker accepts read data.
- mem_data_i  input  32  PTE read data.

## Operation
- PTE: V=[0], R=[1], W=[2], X=[3], PPN=[31:10]; leaf iff R|X.
- States: IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP.
- IDLE: walk_req_ready_o=1; on walk_req_valid_i latch vaddr -> L1_REQ.
- L1_REQ: mem_addr_o = ROOT_BASE + {vaddr[31:22],2'b00}; mem_req_valid_o=1 until mem_req_ready_i -> L1_WAIT.
- L1_WAIT / L0_WAIT: mem_resp_ready_o=1 for the entire state; on mem_resp_valid_i capture mem_data_i, then evaluate PTE.
- L1 PTE: V=0 or (W & ~R) -> RESP fault; non-leaf -> L0_REQ; leaf -> superpage (see Configuration).
- L0_REQ: mem_addr_o = {pte[29:10], vaddr[21:12], 2'b00}; same handshake -> L0_WAIT.
- L0 PTE: V=0, (W & ~R), or non-leaf -> fault; else ppn = pte[29:10].
- RESP: walk_resp_valid_o=1, ppn/fault stable until walk_resp_ready_i -> IDLE.
- PPN bits [31:30] of any PTE ignored (32-bit physical space).
- Fault: walk_ppn_o=0, walk_fault_o=1; no further memory request issued.

## Timing
- Reset: state IDLE; walk_req_ready_o=1; walk_resp_valid_o, mem_req_valid_o, mem_resp_ready_o, walk_fault_o = 0; walk_ppn_o, mem_addr_o = 0.
- Reset mid-walk: next cycle IDLE with reset values; in-flight memory response is dropped (mem_resp_ready_o=0).
- mem_req_valid_o asserted the cycle after walk request acceptance; mem_addr_o stable while valid and not ready.
- mem_req_valid_o deasserts the cycle after the request handshake; never two outstanding reads.
- L0_REQ entered the cycle after the L1 response handshake; walk_resp_valid_o asserted the cycle after the final response handshake.
- mem_resp_valid_i outside *_WAIT ignored.
- No new walk accepted in the cycle of the walk_resp handshake; earliest acceptance is the following cycle (IDLE).

## Configuration
- PTW_SUPERPAGE_EN defined: leaf L1 PTE is a 4 MB superpage; pte[19:10]!=0 -> fault (misaligned); else ppn = {pte[29:20], vaddr[21:12]}; no L0 access.
- Undefined: any leaf L1 PTE -> fault.

## Structure
- ptw_pkg: state_t enum, PTE bit-position localparams, pte_t packed struct (ppn, rsw/d/a/g/u unused, x, w, r, v).
- Sub-module pte_check: combinational PTE decode (valid, leaf, fault, misaligned) used by both levels.

## Test plan
- ROOT_BASE=0x1000, vaddr 0x0040_3000, mem[0x1004]=0x0000_0801, mem[0x200C]=0x0001_400F -> reads 0x1004 then 0x200C, ppn=0x00050, fault=0.
- Same vaddr, mem[0x1004]=0x2000_000B -> one read; with PTW_SUPERPAGE_EN ppn=0x80003 fault=0; without: ppn=0, fault=1.
- mem[0x1004]=0x0000_0000 -> one read, fault=1, ppn=0; mem[0x1004]=0x0000_0805 (W without R) -> fault=1.
- mem_req_ready_i low 3 cycles and walk_resp_ready_i low 2 cycles -> mem_addr_o/valid and ppn/resp_valid held stable; 1-cycle mem_resp_valid_i pulse still captured.
- rst pulsed during L0_WAIT -> next cycle walk_req_ready_o=1, all valids 0; late mem_resp_valid_i ignored; subsequent walk completes correctly.
